// File: rtl/debug_dump_unit_pkg.sv
// Shared definitions for the debug register-dump responder: FSM encoding and
// default datapath sizes.
package debug_dump_unit_pkg;

   typedef enum logic [1:0] {
      DBG_IDLE  = 2'd0,
      DBG_FETCH = 2'd1,
      DBG_SEND  = 2'd2,
      DBG_DONE  = 2'd3
   } dbg_state_e;

   localparam int DEF_XLEN     = 32;
   localparam int DEF_NUM_REGS = 32;

endpackage

// File: rtl/debug_dump_unit_edge_rise.sv
// Rising-edge detector on a level input; one-cycle pulse when in goes 0->1.
// Kept generic so the UART and trace blocks can reuse it.
module debug_dump_unit_edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic in_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) in_q <= 1'b0;
      else      in_q <= in;
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/debug_dump_unit.sv
// Debug dump responder: on a rising debug edge, stalls the core and streams
// every architectural register out over a valid/ready port, one word per handshake.
module debug_dump_unit
   import debug_dump_unit_pkg::*;
#(
   parameter int  XLEN     = DEF_XLEN,
   parameter int  NUM_REGS = DEF_NUM_REGS,
   parameter bit  SKIP_X0  = 1'b0,
   localparam int IDXW     = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            debug,
   output logic            cpu_stall,
   output logic [IDXW-1:0] dbg_raddr,
   input  logic [XLEN-1:0] dbg_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [IDXW-1:0] out_index,
   output logic            out_last,
   output logic            done
);

   localparam logic [IDXW-1:0] IDX_FIRST = SKIP_X0 ? IDXW'(1) : '0;
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_REGS - 1);

   dbg_state_e      state, state_nxt;
   logic [IDXW-1:0] idx;
   logic            debug_rise;
   logic            trigger;
   logic            handshake;

   debug_dump_unit_edge_rise u_edge (
      .clk   (clk),
      .rst   (rst),
      .in    (debug),
      .pulse (debug_rise)
   );

   // Edges outside IDLE are dropped on purpose, never queued.
   assign trigger   = debug_rise & (state == DBG_IDLE);
   assign handshake = (state == DBG_SEND) & out_ready;
   assign dbg_raddr = idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= DBG_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         DBG_IDLE:  if (trigger) state_nxt = DBG_FETCH;
         DBG_FETCH: state_nxt = DBG_SEND;
         DBG_SEND:  if (handshake) state_nxt = out_last ? DBG_DONE : DBG_FETCH;
         DBG_DONE:  state_nxt = DBG_IDLE;
         default:   state_nxt = DBG_IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      done      = 1'b0;
      unique case (state)
         DBG_SEND: out_valid = 1'b1;
         DBG_DONE: done      = 1'b1;
         default:  ;
      endcase
   end

   // Stall is a flop fed from the next state, so it rises on the trigger edge
   // and the core never sees a decode glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx       <= '0;
         cpu_stall <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
      end else begin
         cpu_stall <= (state_nxt != DBG_IDLE);
         if (trigger)
            idx <= IDX_FIRST;
         else if (handshake && !out_last)
            idx <= idx + 1'b1;
         if (state == DBG_FETCH) begin
            out_data  <= dbg_rdata;
            out_index <= idx;
            out_last  <= (idx == IDX_LAST);
         end
      end
   end

endmodule

// File: tb/tb_debug_dump_unit.sv
// Randomized bench for debug_dump_unit: a behavioural core and register file
// drive two instances (x0 included / x0 skipped); dumps are checked against a snapshot.
module tb_debug_dump_unit;

   localparam int XLEN = 32;
   localparam int NR   = 32;
   localparam int IW   = $clog2(NR);

   logic            clk = 1'b0;
   logic            rst;
   logic            debug     [2];
   logic            out_ready [2];
   logic            cpu_stall [2];
   logic            out_valid [2];
   logic            out_last  [2];
   logic            done      [2];
   logic [IW-1:0]   dbg_raddr [2];
   logic [IW-1:0]   out_index [2];
   logic [XLEN-1:0] dbg_rdata [2];
   logic [XLEN-1:0] out_data  [2];

   logic [XLEN-1:0] regs [NR];
   int unsigned     pc;
   bit              core_en;
   int              checks = 0;
   int              errors = 0;
   logic [XLEN-1:0] sig_a, sig_b;

   always #5 clk = ~clk;

   assign dbg_rdata[0] = regs[dbg_raddr[0]];
   assign dbg_rdata[1] = regs[dbg_raddr[1]];

   debug_dump_unit #(.XLEN(XLEN), .NUM_REGS(NR), .SKIP_X0(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .debug(debug[0]), .cpu_stall(cpu_stall[0]),
      .dbg_raddr(dbg_raddr[0]), .dbg_rdata(dbg_rdata[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_data(out_data[0]), .out_index(out_index[0]),
      .out_last(out_last[0]), .done(done[0])
   );

   debug_dump_unit #(.XLEN(XLEN), .NUM_REGS(NR), .SKIP_X0(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .debug(debug[1]), .cpu_stall(cpu_stall[1]),
      .dbg_raddr(dbg_raddr[1]), .dbg_rdata(dbg_rdata[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_data(out_data[1]), .out_index(out_index[1]),
      .out_last(out_last[1]), .done(done[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle: wait for the falling edge, then let the core run a store if not stalled.
   task automatic tick(input int k);
      @(negedge clk);
      if (core_en && !cpu_stall[k]) begin
         regs[pc[6:2]] = $urandom;
         pc += 4;
      end
   endtask

   task automatic check_outputs_zero(input int k, input string tag);
      check({tag, "_valid"}, out_valid[k], 0);
      check({tag, "_data"},  out_data[k],  0);
      check({tag, "_index"}, out_index[k], 0);
      check({tag, "_last"},  out_last[k],  0);
      check({tag, "_done"},  done[k],      0);
      check({tag, "_stall"}, cpu_stall[k], 0);
      check({tag, "_raddr"}, dbg_raddr[k], 0);
   endtask

   // Runs one dump on instance k. ready_rand: random backpressure; bp_word: word number
   // held off for 7 cycles (-1 none); hold: debug kept high; repulse: debug re-pulsed
   // mid-dump; abort_at: assert reset after this many words (-1 none).
   task automatic run_dump(input int k, input bit ready_rand, input int bp_word,
                           input bit hold, input bit repulse, input int abort_at,
                           output logic [XLEN-1:0] sig);
      logic [XLEN-1:0] snap [NR];
      logic [XLEN-1:0] prev_data;
      logic [IW-1:0]   prev_idx;
      int unsigned     snap_pc;
      int              first, nwords, n, waits, stall_cnt, bp_cnt, reg_bad, exp_i;
      bit              prev_hold, seen_done, aborted, r;
      first = k;
      nwords = NR - first;
      n = 0; waits = 0; bp_cnt = 0; reg_bad = 0;
      prev_hold = 0; seen_done = 0; aborted = 0;
      prev_data = '0; prev_idx = '0;
      sig = '0;
      debug[k] = 1'b0;
      tick(k);
      debug[k] = 1'b1;
      out_ready[k] = 1'b1;
      tick(k);
      check("stall_on_trigger", cpu_stall[k], 1);
      check("valid_in_fetch", out_valid[k], 0);
      snap = regs;
      snap_pc = pc;
      stall_cnt = 1;
      for (int cyc = 0; cyc < 2000 && !seen_done && !aborted; cyc++) begin
         tick(k);
         if (cpu_stall[k]) stall_cnt++;
         if (cyc == 0) check("latency_valid", out_valid[k], 1);
         if (!hold && cyc == 2) debug[k] = 1'b0;
         if (repulse && cyc == 10) debug[k] = 1'b1;
         if (repulse && cyc == 13) debug[k] = 1'b0;
         if (prev_hold) begin
            check("bp_valid", out_valid[k], 1);
            check("bp_data", out_data[k], prev_data);
            check("bp_index", out_index[k], prev_idx);
         end
         prev_hold = 0;
         if (done[k]) begin
            check("words_before_done", n, nwords);
            seen_done = 1;
         end else if (out_valid[k]) begin
            if (n == bp_word && bp_cnt < 7) begin
               r = 1'b0;
               bp_cnt++;
            end else begin
               r = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            out_ready[k] = r;
            if (r) begin
               exp_i = first + n;
               check("data", out_data[k], snap[exp_i]);
               check("index", out_index[k], exp_i);
               check("last", out_last[k], exp_i == NR - 1);
               sig = (sig * 31) ^ out_data[k];
               n++;
               if (abort_at >= 0 && n == abort_at) begin
                  #2 rst = 1'b0;
                  #1 check_outputs_zero(k, "rst_async");
                  debug[k] = 1'b0;
                  tick(k);
                  tick(k);
                  rst = 1'b1;
                  tick(k);
                  tick(k);
                  check("rst_idle_stall", cpu_stall[k], 0);
                  check("rst_idle_valid", out_valid[k], 0);
                  check("rst_no_done", done[k], 0);
                  aborted = 1;
               end
            end else begin
               waits++;
               prev_hold = 1;
               prev_data = out_data[k];
               prev_idx  = out_index[k];
            end
         end else begin
            out_ready[k] = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      if (aborted) return;
      if (!seen_done) check("done_timeout", 0, 1);
      check("stall_cycles", stall_cnt, 2 * nwords + 1 + waits);
      check("pc_frozen", pc, snap_pc);
      foreach (snap[i]) if (regs[i] !== snap[i]) reg_bad++;
      check("regs_frozen", reg_bad, 0);
      tick(k);
      check("done_one_cycle", done[k], 0);
      check("stall_released", cpu_stall[k], 0);
      if (core_en) check("core_resumes", pc, snap_pc + 4);
      for (int i = 0; i < 4; i++) tick(k);
      check("no_retrigger", cpu_stall[k], 0);
      debug[k] = 1'b0;
      tick(k);
   endtask

   initial begin
      rst = 1'b0;
      core_en = 0;
      pc = 0;
      for (int k = 0; k < 2; k++) begin
         debug[k] = 1'b0;
         out_ready[k] = 1'b1;
      end
      for (int i = 0; i < NR; i++) regs[i] = 32'hA000_0000 + i;
      #1 check_outputs_zero(0, "reset");
      check_outputs_zero(1, "reset1");
      tick(0);
      tick(0);
      rst = 1'b1;
      tick(0);

      run_dump(0, 0, -1, 0, 0, -1, sig_a);
      run_dump(1, 0, -1, 0, 0, -1, sig_a);

      foreach (regs[i]) regs[i] = $urandom;
      run_dump(0, 0, 3, 0, 0, -1, sig_a);

      run_dump(0, 1, -1, 1, 0, -1, sig_a);
      run_dump(0, 1, -1, 0, 1, -1, sig_b);
      check("redump_identical", sig_b, sig_a);

      run_dump(0, 0, -1, 0, 0, 5, sig_a);
      run_dump(0, 1, -1, 0, 0, -1, sig_a);

      core_en = 1;
      for (int i = 0; i < 20; i++) tick(0);
      run_dump(0, 1, 2, 0, 0, -1, sig_a);
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < int'($urandom_range(1, 15)); i++) tick(j % 2);
         run_dump(j % 2, 1, int'($urandom_range(0, 30)), 0, 0, -1, sig_a);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
